sd_sector_arbiter: RTL
======================

SD_SECTOR_ARBITER -- requirements
Module: sd_sector_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 24'd12000000, clk_sys cycles allowed between command issue and first sd_ack high before the request is aborted.
REQ-002 clk_sys  in  1  single system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_rd  in  2  per-requester sector read request, level, bit n = requester n.
REQ-005 req_wr  in  2  per-requester sector write request, level.
REQ-006 req_lba0, req_lba1  in  32 each  sector address of requester 0 and 1.
REQ-007 req_din0, req_din1  in  8 each  write data from each requester's sector buffer.
REQ-008 req_busy  out  2  one-hot, high while that requester owns the SD port.
REQ-009 req_done  out  2  one-cycle pulse on successful completion.
REQ-010 req_err  out  2  one-cycle pulse on timeout abort.
REQ-011 buff_wr  out  2  sd_dout_strobe qualified by owner.
REQ-012 buff_rd  out  2  sd_din_strobe qualified by owner.
REQ-013 sd_lba  out  32;  sd_rd, sd_wr  out  1 each  command to the SD emulation port.
REQ-014 sd_ack  in  1  transfer-active flag from the SD emulation port.
REQ-015 sd_dout_strobe, sd_din_strobe  in  1 each;  sd_din  out  8, muxed from owner's req_dinN.

Function
REQ-016 States IDLE, ISSUE, XFER, DONE; encoding in shared package.
REQ-017 sd_ack passes through a 2-flop synchronizer; all state decisions use the synchronized value ack_s.
REQ-018 IDLE: when any req_rd|req_wr bit set, grant by round-robin -- requester other than last_grant wins if both pending, else the single pending one; transition to ISSUE next cycle.
REQ-019 At grant: latch owner, sd_lba <= req_lbaN, direction <= write if req_wr[N] else read (write wins when both set); req_busy[N] <= 1; timeout counter <= 0.
REQ-020 ISSUE: sd_rd or sd_wr held high per direction; on ack_s high -> deassert sd_rd/sd_wr same edge, go XFER; counter reaching TIMEOUT-1 -> deassert, pulse req_err[N], go IDLE.
REQ-021 XFER: on ack_s low -> go DONE; no timeout in XFER.
REQ-022 DONE: pulse req_done[N] one cycle, clear req_busy, last_grant <= owner, go IDLE; earliest regrant one cycle after DONE.
REQ-023 buff_wr[N] = sd_dout_strobe & req_busy[N]; buff_rd[N] = sd_din_strobe & req_busy[N]; combinational, zero latency; both 0 when IDLE.
REQ-024 sd_din = owner's req_dinN combinationally; req_din0 when IDLE.
REQ-025 Request deassertion after grant is ignored; the latched operation completes (done or err).
REQ-026 sd_lba stable from grant until next grant.
REQ-027 Timeout counter 24 bits, saturates, cleared at each grant.
REQ-028 sd_rd and sd_wr are never simultaneously high.

Reset
REQ-029 Reset -> state IDLE, sd_rd=0, sd_wr=0, sd_lba=0, req_busy=0, req_done=0, req_err=0, last_grant=1 (requester 0 wins first), synchronizer flops 0, counter 0.
REQ-030 Reset mid-transfer aborts without req_done/req_err pulse; sd_rd/sd_wr low on the first edge with reset high.

Structure
REQ-031 Package sd_arb_pkg holds state enum, requester count constant (2), TIMEOUT default.
REQ-032 One sub-module, sync2, the 2-flop synchronizer for sd_ack; rest flat.

Verification
REQ-033 req_rd=2'b01, lba0=0x1234 -> sd_rd high 1 cycle after, sd_lba=0x1234; ack high 10 cycles -> 512 sd_dout_strobe give 512 buff_wr[0], buff_wr[1]=0; req_done[0] pulses once.
REQ-034 req_rd=2'b11 held continuously -> grants alternate 0,1,0,1 across four transfers.
REQ-035 req_rd[1]=req_wr[1]=1 -> sd_wr asserted, sd_rd stays 0.
REQ-036 TIMEOUT=100, sd_ack never high -> sd_rd drops after 100 cycles in ISSUE, req_err[0] pulses, no req_done.
REQ-037 reset asserted mid-XFER -> next edge all outputs zero, no done/err; new req_wr[1] after reset served normally.
REQ-038 Requester 0 drops req_rd 1 cycle after grant -> transfer still completes with req_done[0].

Source files
------------

// File: rtl/sd_arb_pkg.sv
// ---------------------------------------------------------------------------
// sd_arb_pkg
// Shared definitions for the two-requester SD sector arbiter:
//   - N_REQ            : number of requesters sharing the SD emulation port
//   - TIMEOUT_DEFAULT  : default cycles allowed between command issue and the
//                        first synchronized sd_ack before the request aborts
//   - arb_state_t      : arbiter FSM state encoding
//   - grant_pick()     : round-robin winner selection
//   - req_onehot()     : requester index to one-hot busy/done/err vector
// ---------------------------------------------------------------------------
package sd_arb_pkg;

  localparam int N_REQ = 2;

  localparam logic [23:0] TIMEOUT_DEFAULT = 24'd12000000;

  localparam logic [23:0] CNT_MAX = 24'hFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  // Round-robin pick among pending requesters. When both are pending the one
  // that did not win last time gets the port; otherwise the single pending
  // requester wins. Only meaningful when at least one bit of pending is set.
  function automatic logic grant_pick(input logic [N_REQ-1:0] pending,
                                      input logic             last_grant);
    logic winner;
    if (pending == 2'b11) begin
      winner = ~last_grant;
    end else begin
      winner = pending[1];
    end
    return winner;
  endfunction

  function automatic logic [N_REQ-1:0] req_onehot(input logic idx);
    logic [N_REQ-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/sd_sector_arbiter_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for the sd_ack flag coming from the SD emulation
// port. Both flops clear on reset so a stale acknowledge seen before reset
// cannot leak into the first command issued afterwards.
// Ports:
//   clk_sys  in  system clock
//   reset    in  synchronous active-high reset
//   d        in  asynchronous input
//   q        out synchronized copy of d, two clk_sys cycles later
// ---------------------------------------------------------------------------
module sync2 (
  input  logic clk_sys,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_reg;
  logic s2_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
    end else begin
      s1_reg <= d;
      s2_reg <= s1_reg;
    end
  end

  assign q = s2_reg;

endmodule

// File: rtl/sd_sector_arbiter.sv
// ---------------------------------------------------------------------------
// sd_sector_arbiter
// Shares one SD emulation port between two sector-buffer requesters.
// A requester raises req_rd/req_wr (level); the arbiter grants round-robin,
// latches the sector address and direction, holds sd_rd or sd_wr until the
// synchronized acknowledge rises, waits for it to fall again, then pulses
// req_done. If no acknowledge arrives within TIMEOUT cycles the command is
// dropped and req_err pulses instead.
// Ports:
//   clk_sys              in   system clock, rising edge
//   reset                in   synchronous active-high reset
//   req_rd / req_wr      in   [1:0] per-requester read / write request
//   req_lba0 / req_lba1  in   [31:0] sector address per requester
//   req_din0 / req_din1  in   [7:0] write data per requester
//   req_busy             out  [1:0] one-hot, owner of the SD port
//   req_done / req_err   out  [1:0] one-cycle completion / timeout pulses
//   buff_wr / buff_rd    out  [1:0] data strobes routed to the owner
//   sd_lba               out  [31:0] latched sector address
//   sd_rd / sd_wr        out  command lines to the SD port
//   sd_ack               in   transfer-active flag (asynchronous)
//   sd_dout_strobe       in   read-data strobe from the SD port
//   sd_din_strobe        in   write-data strobe from the SD port
//   sd_din               out  [7:0] owner's write data
// ---------------------------------------------------------------------------
module sd_sector_arbiter
  import sd_arb_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  input  logic [7:0]  req_din0,
  input  logic [7:0]  req_din1,
  output logic [1:0]  req_busy,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [1:0]  buff_wr,
  output logic [1:0]  buff_rd,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_dout_strobe,
  input  logic        sd_din_strobe,
  output logic [7:0]  sd_din
);

  // -------------------------------------------------------------------------
  // Acknowledge synchronizer
  // -------------------------------------------------------------------------
  logic ack_s;

  sync2 u_sync_ack (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (sd_ack),
    .q       (ack_s)
  );

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  arb_state_t        state_reg,      state_next;
  logic              owner_reg,      owner_next;
  logic              last_grant_reg, last_grant_next;
  logic [23:0]       cnt_reg,        cnt_next;
  logic [31:0]       sd_lba_reg,     sd_lba_next;
  logic              sd_rd_reg,      sd_rd_next;
  logic              sd_wr_reg,      sd_wr_next;
  logic [N_REQ-1:0]  busy_reg,       busy_next;
  logic [N_REQ-1:0]  done_reg,       done_next;
  logic [N_REQ-1:0]  err_reg,        err_next;

  logic [N_REQ-1:0]  pending;
  logic              grant_sel;
  logic              timeout_hit;

  assign pending     = req_rd | req_wr;
  assign grant_sel   = grant_pick(pending, last_grant_reg);
  assign timeout_hit = (cnt_reg == (TIMEOUT - 24'd1));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;   // requester 0 wins the first contested grant
      cnt_reg        <= '0;
      sd_lba_reg     <= '0;
      sd_rd_reg      <= 1'b0;
      sd_wr_reg      <= 1'b0;
      busy_reg       <= '0;
      done_reg       <= '0;
      err_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      sd_lba_reg     <= sd_lba_next;
      sd_rd_reg      <= sd_rd_next;
      sd_wr_reg      <= sd_wr_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    sd_lba_next     = sd_lba_reg;
    sd_rd_next      = sd_rd_reg;
    sd_wr_next      = sd_wr_reg;
    busy_next       = busy_reg;
    done_next       = '0;       // pulses last exactly one cycle
    err_next        = '0;

    case (state_reg)
      ST_IDLE: begin
        if (pending != '0) begin
          // Grant: everything about the operation is captured here, so the
          // requester may drop its request right away without effect.
          owner_next  = grant_sel;
          sd_lba_next = grant_sel ? req_lba1 : req_lba0;
          // Write wins when a requester asserts both lines; the two command
          // lines are therefore mutually exclusive by construction.
          sd_wr_next  = req_wr[grant_sel];
          sd_rd_next  = ~req_wr[grant_sel];
          busy_next   = req_onehot(grant_sel);
          cnt_next    = '0;
          state_next  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (ack_s) begin
          sd_rd_next = 1'b0;
          sd_wr_next = 1'b0;
          state_next = ST_XFER;
        end else if (timeout_hit) begin
          // Abort: report to the owner and release the port. last_grant is
          // left alone so an aborted requester does not lose its turn.
          sd_rd_next = 1'b0;
          sd_wr_next = 1'b0;
          err_next   = busy_reg;
          busy_next  = '0;
          state_next = ST_IDLE;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 24'd1;
        end
      end

      ST_XFER: begin
        // The SD side may take arbitrarily long to move the sector.
        if (!ack_s) begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        done_next       = busy_reg;
        busy_next       = '0;
        last_grant_next = owner_reg;
        state_next      = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign req_busy = busy_reg;
  assign req_done = done_reg;
  assign req_err  = err_reg;
  assign sd_lba   = sd_lba_reg;
  assign sd_rd    = sd_rd_reg;
  assign sd_wr    = sd_wr_reg;

  // Data strobes go straight through to whoever owns the port; busy is all
  // zero when idle so nothing leaks to either buffer.
  assign buff_wr  = {N_REQ{sd_dout_strobe}} & busy_reg;
  assign buff_rd  = {N_REQ{sd_din_strobe}}  & busy_reg;

  // Requester 0's data is presented whenever requester 1 does not own the port.
  assign sd_din   = busy_reg[1] ? req_din1 : req_din0;

endmodule
